// File: rtl/flit_depacketizer.sv
// flit_depacketizer
//   Reassembles n-flit packets (head, n-2 bodies, tail) into one wide packet
//   and offers it on a valid/ready output. Packets addressed to another node
//   are consumed and counted as drops. Protocol violations pulse err.
//
//   Ports
//     clk, rst     clock, asynchronous active-high reset
//     flit_in      16-bit flit, [15:14] = type (00 head, 01 body, 10 tail)
//     flit_valid   flit_in is valid
//     flit_ready   block accepts a flit this cycle
//     pkt_src      source node of the held packet
//     pkt_des      destination node of the held packet
//     pkt_data     reassembled payload, head data6 in the top bits
//     pkt_valid    packet outputs are valid
//     pkt_ready    consumer accepts the packet
//     err          one-cycle pulse per protocol violation
//     drop_cnt     saturating count of misrouted packets discarded
//
//   state | meaning
//   IDLE  | waiting for a head flit
//   RECV  | collecting bodies/tail of a packet addressed to MY_ID
//   DROP  | consuming bodies/tail of a packet addressed elsewhere
//   HOLD  | packet complete, waiting for the consumer handshake
module flit_depacketizer #(
  parameter int          n     = 4,
  parameter logic [3:0]  MY_ID = 4'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       flit_in,
  input  logic              flit_valid,
  output logic              flit_ready,
  output logic [3:0]        pkt_src,
  output logic [3:0]        pkt_des,
  output logic [14*n-9:0]   pkt_data,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  output logic              err,
  output logic [7:0]        drop_cnt
);

  localparam int IW = (n > 2) ? $clog2(n) : 1;
  localparam logic [IW-1:0] LAST = IW'(n - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] DROP = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_BODY = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;

  logic [1:0]    state;
  logic [IW-1:0] index;
  logic [1:0]    typ;
  logic [1:0]    exp_typ;
  logic          accept;

  assign flit_ready = !rst && (state != HOLD);
  assign pkt_valid  = (state == HOLD);
  assign accept     = flit_valid && flit_ready;
  assign typ        = flit_in[15:14];
  assign exp_typ    = (index == LAST) ? T_TAIL : T_BODY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      index    <= '0;
      err      <= 1'b0;
      drop_cnt <= 8'd0;
      pkt_src  <= 4'd0;
      pkt_des  <= 4'd0;
      pkt_data <= '0;
    end else begin
      err <= 1'b0;
      // A head is handled identically in IDLE, RECV and DROP; outside IDLE
      // it also abandons the packet in progress and flags the violation.
      if (accept && typ == T_HEAD) begin
        err                     <= (state != IDLE);
        pkt_src                 <= flit_in[13:10];
        pkt_des                 <= flit_in[9:6];
        pkt_data[14*n-9 -: 6]   <= flit_in[5:0];
        index                   <= IW'(1);
        state                   <= (flit_in[9:6] == MY_ID) ? RECV : DROP;
      end else begin
        case (state)
          IDLE: begin
            if (accept) err <= 1'b1;
          end
          RECV, DROP: begin
            if (accept) begin
              if (typ == exp_typ) begin
                if (state == RECV) begin
                  for (int k = 1; k < n; k++) begin
                    if (index == IW'(k)) pkt_data[14*(n-k)-1 -: 14] <= flit_in[13:0];
                  end
                end
                if (typ == T_TAIL) begin
                  index <= '0;
                  if (state == RECV) begin
                    state <= HOLD;
                  end else begin
                    state <= IDLE;
                    if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                  end
                end else begin
                  index <= index + 1'b1;
                end
              end else begin
                err   <= 1'b1;
                index <= '0;
                state <= IDLE;
              end
            end
          end
          HOLD: begin
            if (pkt_ready) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flit_depacketizer.sv
module tb_flit_depacketizer;
  localparam int         N     = 4;
  localparam logic [3:0] MY_ID = 4'h3;
  localparam int         DW    = 14*N-8;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   flit_in;
  logic          flit_valid;
  logic          flit_ready;
  logic [3:0]    pkt_src;
  logic [3:0]    pkt_des;
  logic [DW-1:0] pkt_data;
  logic          pkt_valid;
  logic          pkt_ready;
  logic          err;
  logic [7:0]    drop_cnt;

  int total = 0;
  int bad   = 0;

  // Packet-level reference: accepted flits of the packet in progress are
  // queued; the packet is judged when its tail arrives.
  logic [15:0]   q[$];
  bit            m_hold;
  logic [3:0]    m_src, m_des;
  logic [63:0]   m_data;
  int            m_drop;
  bit            m_err;

  flit_depacketizer #(.n(N), .MY_ID(MY_ID)) dut (
    .clk(clk), .rst(rst), .flit_in(flit_in), .flit_valid(flit_valid),
    .flit_ready(flit_ready), .pkt_src(pkt_src), .pkt_des(pkt_des),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .err(err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_flit(input logic [15:0] f);
    logic [1:0]  t;
    logic [15:0] h;
    int          want;
    t = f[15:14];
    if (t == 2'b00) begin
      if (q.size() > 0) m_err = 1;
      q.delete();
      q.push_back(f);
    end else if (q.size() == 0) begin
      m_err = 1;
    end else begin
      want = (q.size() == N-1) ? 2 : 1;
      if (int'(t) != want) begin
        m_err = 1;
        q.delete();
      end else begin
        q.push_back(f);
        if (t == 2'b10) begin
          h = q[0];
          if (h[9:6] == MY_ID) begin
            m_hold = 1;
            m_src  = h[13:10];
            m_des  = h[9:6];
            m_data = 64'(h[5:0]);
            for (int i = 1; i < N; i++) m_data = (m_data << 14) | 64'(q[i][13:0]);
          end else if (m_drop < 255) begin
            m_drop++;
          end
          q.delete();
        end
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [15:0] f, input logic pr, output logic acc);
    flit_valid = v;
    flit_in    = f;
    pkt_ready  = pr;
    #1;
    chk("flit_ready", 64'(flit_ready), 64'(!m_hold));
    @(posedge clk);
    acc   = v && !m_hold;
    m_err = 0;
    if (m_hold) begin
      if (pr) m_hold = 0;
    end else if (v) begin
      model_flit(f);
    end
    #1;
    chk("err", 64'(err), 64'(m_err));
    chk("pkt_valid", 64'(pkt_valid), 64'(m_hold));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    if (m_hold) begin
      chk("pkt_src", 64'(pkt_src), 64'(m_src));
      chk("pkt_des", 64'(pkt_des), 64'(m_des));
      chk("pkt_data", 64'(pkt_data), m_data);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] f, input logic pr);
    logic acc;
    int   n_try;
    acc = 0;
    n_try = 0;
    while (!acc && n_try < 50) begin
      cycle(1'b1, f, pr, acc);
      n_try++;
    end
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic idle(input int k, input logic pr);
    logic acc;
    for (int i = 0; i < k; i++) cycle(1'b0, 16'h0000, pr, acc);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    flit_valid = 1'b0;
    pkt_ready  = 1'b0;
    flit_in    = 16'h0000;
    #1;
    q.delete();
    m_hold = 0;
    m_drop = 0;
    chk("rst_flit_ready", 64'(flit_ready), 64'd0);
    chk("rst_pkt_valid", 64'(pkt_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_src_des", 64'({pkt_src, pkt_des}), 64'd0);
    chk("rst_pkt_data", 64'(pkt_data), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic        acc;
    logic [15:0] pf[N];
    logic [3:0]  src, des;
    int          idx;

    do_reset();

    // Nominal packet with an always-ready consumer.
    send(16'h14EA, 1); send(16'h5234, 1); send(16'h4ABC, 1); send(16'hBFFF, 1);
    chk("p1_data", 64'(pkt_data), 64'hA92342AF3FFF);
    chk("p1_src_des", 64'({pkt_src, pkt_des}), 64'h53);
    chk("p1_valid", 64'(pkt_valid), 64'd1);
    idle(1, 1);
    chk("p1_valid_1cyc", 64'(pkt_valid), 64'd0);

    // Stalled consumer with a second head waiting, then back-to-back packet.
    send(16'h14EA, 0); send(16'h5234, 0); send(16'h4ABC, 0); send(16'hBFFF, 0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h14EA, 0, acc);
    chk("hold_data", 64'(pkt_data), 64'hA92342AF3FFF);
    chk("hold_no_accept", 64'(acc), 64'd0);
    cycle(1'b1, 16'h14EA, 1, acc);
    chk("handshake_no_accept", 64'(acc), 64'd0);
    send(16'h14EA, 1);
    send(16'h5234, 1); send(16'h4ABC, 1); send(16'hBFFF, 1);
    idle(2, 1);

    // Misrouted packet is dropped and counted.
    send(16'h15EA, 1); send(16'h5234, 1); send(16'h4ABC, 1); send(16'hBFFF, 1);
    chk("drop_cnt_one", 64'(drop_cnt), 64'd1);
    idle(2, 1);

    // Unexpected head restarts the packet.
    send(16'h14EA, 1); send(16'h5234, 1);
    send(16'h14EA, 1);
    chk("restart_err", 64'(err), 64'd1);
    send(16'h5234, 1); send(16'h4ABC, 1); send(16'hBFFF, 1);
    chk("restart_data", 64'(pkt_data), 64'hA92342AF3FFF);
    idle(2, 1);

    // Non-head flits in IDLE.
    send(16'h5234, 1);
    chk("idle_body_err", 64'(err), 64'd1);
    send(16'hC000, 1);
    chk("idle_ill_err", 64'(err), 64'd1);
    idle(1, 1);

    // Reset mid-packet, then a full packet.
    send(16'h14EA, 1); send(16'h5234, 1);
    do_reset();
    send(16'h14EA, 1); send(16'h5234, 1); send(16'h4ABC, 1); send(16'hBFFF, 1);
    chk("post_rst_data", 64'(pkt_data), 64'hA92342AF3FFF);
    idle(2, 1);

    // Randomised packets with occasional corruption, stalls and resets.
    for (int p = 0; p < 150; p++) begin
      src = 4'($urandom_range(0, 15));
      des = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : MY_ID;
      pf[0] = {2'b00, src, des, 6'($urandom_range(0, 63))};
      for (int i = 1; i < N; i++)
        pf[i] = {((i == N-1) ? 2'b10 : 2'b01), 14'($urandom_range(0, 16383))};
      if ($urandom_range(0, 9) == 0) begin
        idx = $urandom_range(0, N-1);
        pf[idx][15:14] = 2'($urandom_range(0, 3));
      end
      for (int i = 0; i < N; i++) begin
        acc = 0;
        for (int t = 0; t < 60 && !acc; t++)
          cycle(($urandom_range(0, 3) != 0), pf[i], 1'($urandom_range(0, 1)), acc);
        if (!acc) chk("rand_timeout", 64'(acc), 64'd1);
      end
      if ($urandom_range(0, 39) == 0) do_reset();
    end
    idle(3, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
